// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: accepts one RV32 instruction at a time,
// walks it through DECODE / MUL_WAIT / MEM / WB and emits datapath controls.
module multicycle_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned MUL_EN  = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    output logic             instr_ready,
    input  logic             mem_ready,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUOp,
    output logic             mul_start,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned MC_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MUL_WAIT,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        K_ILL,
        K_ALU_R,
        K_MUL,
        K_ALU_I,
        K_LOAD,
        K_STORE,
        K_BRANCH,
        K_JAL,
        K_JALR,
        K_LUI,
        K_AUIPC
    } kind_t;

    state_t          state;
    logic [31:0]     instr_q;
    logic [MC_W-1:0] mul_cnt;
    kind_t           kind_in;
    kind_t           kind_q;
    logic            unused_instr_bits;

    // Instruction class from opcode, with MUL carved out of the R-type space
    function automatic kind_t classify(input logic [31:0] w);
        kind_t k;
        k = K_ILL;
        case (w[6:0])
            OP_R: begin
                if (w[31:25] == 7'b0000001 && w[14:12] == 3'b000)
                    k = (MUL_EN != 0) ? K_MUL : K_ILL;
                else
                    k = K_ALU_R;
            end
            OP_I:     k = K_ALU_I;
            OP_LOAD:  k = K_LOAD;
            OP_STORE: k = K_STORE;
            OP_BR:    k = K_BRANCH;
            OP_JAL:   k = K_JAL;
            OP_JALR:  k = K_JALR;
            OP_LUI:   k = K_LUI;
            OP_AUIPC: k = K_AUIPC;
            default:  k = K_ILL;
        endcase
        return k;
    endfunction

    // ALU class per instruction kind
    function automatic logic [1:0] aluop_of(input kind_t k);
        logic [1:0] r;
        case (k)
            K_ALU_R:  r = 2'b10;
            K_ALU_I:  r = 2'b11;
            K_BRANCH: r = 2'b01;
            default:  r = 2'b00;
        endcase
        return r;
    endfunction

    // Writeback source per instruction kind
    function automatic logic [1:0] memtoreg_of(input kind_t k);
        logic [1:0] r;
        case (k)
            K_LOAD:        r = 2'b01;
            K_JAL, K_JALR: r = 2'b10;
            K_MUL:         r = 2'b11;
            default:       r = 2'b00;
        endcase
        return r;
    endfunction

    // Immediate operand select per instruction kind
    function automatic logic alusrc_of(input kind_t k);
        logic r;
        case (k)
            K_ALU_I, K_LOAD, K_STORE, K_JALR, K_LUI, K_AUIPC: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Incoming word decodes the controls registered at accept; latched word steers DECODE/MEM
    assign kind_in = classify(instruction);
    assign kind_q  = classify(instr_q);

    // Register/immediate fields of the latched word are not needed by the controller
    assign unused_instr_bits = ^{instr_q[24:15], instr_q[11:7]};

    // Handshake and status straight from the state register
    assign instr_ready = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE);

    // Controller FSM with registered datapath controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            mul_cnt     <= '0;
            instr_count <= '0;
            Branch      <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            ALUSrc      <= 1'b0;
            RegWrite    <= 1'b0;
            MemtoReg    <= 2'b00;
            ALUOp       <= 2'b00;
            mul_start   <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            illegal   <= 1'b0;
            Branch    <= 1'b0;
            RegWrite  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q   <= instruction;
                        state     <= S_DECODE;
                        ALUOp     <= aluop_of(kind_in);
                        MemtoReg  <= memtoreg_of(kind_in);
                        ALUSrc    <= alusrc_of(kind_in);
                        mul_start <= (kind_in == K_MUL);
                        illegal   <= (kind_in == K_ILL);
                    end
                end
                S_DECODE: begin
                    case (kind_q)
                        K_ILL: begin
                            state    <= S_IDLE;
                            ALUOp    <= 2'b00;
                            MemtoReg <= 2'b00;
                            ALUSrc   <= 1'b0;
                        end
                        K_MUL: begin
                            state   <= S_MUL_WAIT;
                            mul_cnt <= MC_W'(MUL_LAT - 1);
                        end
                        K_LOAD: begin
                            state   <= S_MEM;
                            MemRead <= 1'b1;
                        end
                        K_STORE: begin
                            state    <= S_MEM;
                            MemWrite <= 1'b1;
                        end
                        default: begin
                            state    <= S_WB;
                            RegWrite <= (kind_q != K_BRANCH);
                            Branch   <= (kind_q == K_BRANCH);
                        end
                    endcase
                end
                S_MUL_WAIT: begin
                    if (mul_cnt == '0) begin
                        state    <= S_WB;
                        RegWrite <= 1'b1;
                    end else begin
                        mul_cnt <= mul_cnt - MC_W'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (kind_q == K_LOAD) begin
                            state    <= S_WB;
                            RegWrite <= 1'b1;
                        end else begin
                            state       <= S_IDLE;
                            instr_count <= instr_count + CNT_W'(1);
                            ALUOp       <= 2'b00;
                            MemtoReg    <= 2'b00;
                            ALUSrc      <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    state       <= S_IDLE;
                    instr_count <= instr_count + CNT_W'(1);
                    ALUOp       <= 2'b00;
                    MemtoReg    <= 2'b00;
                    ALUSrc      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
